// File: rtl/gear_shift_sched_pkg.sv
// ----------------------------------------------------------------------------
// gear_pkg
// Shared definitions for the gear shift scheduler:
//   gear_state_e  - scheduler FSM states (IDLE, DEBOUNCE, SHIFT_DOWN, COMMIT)
//   GEAR_INVALID  - switch code that has no gear behind it
//   gear_ceiling  - maximum speed level allowed in a given gear
// ----------------------------------------------------------------------------
package gear_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DEBOUNCE   = 2'd1,
        SHIFT_DOWN = 2'd2,
        COMMIT     = 2'd3
    } gear_state_e;

    localparam logic [2:0] GEAR_INVALID = 3'd7;

    // Neutral and the invalid code both map to a zero ceiling; gears 1..6
    // follow 2*g+3.
    function automatic logic [3:0] gear_ceiling(input logic [2:0] gear);
        case (gear)
            3'd1:    return 4'd5;
            3'd2:    return 4'd7;
            3'd3:    return 4'd9;
            3'd4:    return 4'd11;
            3'd5:    return 4'd13;
            3'd6:    return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/gear_shift_sched_if.sv
// ----------------------------------------------------------------------------
// gear_shift_sched_if
// Bundles the scheduler's strobe and level signals for whoever sits around
// the scheduler (user input stage, rpm controller, test environment).
//   master : drives tick_1khz, accel_pulse, decel_pulse, gear_sw, speed_level
//            and observes the scheduler outputs
//   slave  : the scheduler's view
// Signalling: there is no valid/ready flow control. Every *_pulse and
// tick_1khz is a one-cycle strobe that is acted on in the cycle it is high;
// nothing is ever held off or back-pressured. Level signals (gear_sw,
// speed_level, max_level, gear_active, busy, fault) are sampled every cycle.
// ----------------------------------------------------------------------------
interface gear_shift_sched_if;
    logic       tick_1khz;
    logic       accel_pulse;
    logic       decel_pulse;
    logic [2:0] gear_sw;
    logic [3:0] speed_level;
    logic       inc_pulse;
    logic       dec_pulse;
    logic [3:0] max_level;
    logic [2:0] gear_active;
    logic       busy;
    logic       fault;

    modport master (
        output tick_1khz, accel_pulse, decel_pulse, gear_sw, speed_level,
        input  inc_pulse, dec_pulse, max_level, gear_active, busy, fault
    );

    modport slave (
        input  tick_1khz, accel_pulse, decel_pulse, gear_sw, speed_level,
        output inc_pulse, dec_pulse, max_level, gear_active, busy, fault
    );
endinterface

// File: rtl/gear_shift_sched.sv
// ----------------------------------------------------------------------------
// gear_shift_sched
// Debounces the gear switch, steps the speed down to the new gear's ceiling
// before committing a lower gear, and arbitrates user accel/decel requests.
// Ports:
//   clk_100mhz, rst_btn          clock, asynchronous active-high reset
//   tick_1khz                    1 kHz strobe gating all timing counters
//   accel_pulse, decel_pulse     user step requests (single cycle)
//   gear_sw[2:0]                 synchronised gear switch
//   speed_level[3:0]             level reported by the rpm controller
//   inc_pulse, dec_pulse         registered step commands (single cycle)
//   max_level[3:0]               ceiling of the committed gear
//   gear_active[2:0]             committed gear
//   busy                         high whenever the FSM is not in IDLE
//   fault                        last debounced gear was the invalid code
//   state_dbg                    current FSM state
// ----------------------------------------------------------------------------
module gear_shift_sched
    import gear_pkg::*;
#(
    parameter int GEAR_STABLE_TICKS = 20,
    parameter int STEP_TICKS        = 50
) (
    input  logic        clk_100mhz,
    input  logic        rst_btn,
    input  logic        tick_1khz,
    input  logic        accel_pulse,
    input  logic        decel_pulse,
    input  logic [2:0]  gear_sw,
    input  logic [3:0]  speed_level,
    output logic        inc_pulse,
    output logic        dec_pulse,
    output logic [3:0]  max_level,
    output logic [2:0]  gear_active,
    output logic        busy,
    output logic        fault,
    output gear_state_e state_dbg
);

    localparam logic [15:0] STABLE_LIM = 16'(GEAR_STABLE_TICKS);
    localparam logic [15:0] STEP_LIM   = 16'(STEP_TICKS);

    gear_state_e state;
    logic [2:0]  target;
    logic [15:0] stable_cnt;
    logic [15:0] step_cnt;

    logic [3:0] target_ceil;
    logic       user_inc;
    logic       user_dec;
    logic       sd_dec;

    assign state_dbg   = state;
    assign target_ceil = gear_ceiling(target);

    // Conflicting requests cancel; each direction is gated by the range.
    assign user_inc = accel_pulse && !decel_pulse && (speed_level < max_level);
    assign user_dec = decel_pulse && !accel_pulse && (speed_level != 4'd0);
    // While stepping down, accel is ignored so decel wins outright.
    assign sd_dec   = decel_pulse && (speed_level != 4'd0);

    always_ff @(posedge clk_100mhz or posedge rst_btn) begin
        if (rst_btn) begin
            state       <= IDLE;
            target      <= 3'd0;
            stable_cnt  <= 16'd0;
            step_cnt    <= 16'd0;
            gear_active <= 3'd0;
            max_level   <= 4'd0;
            inc_pulse   <= 1'b0;
            dec_pulse   <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            // The "&& !x_pulse" terms keep every pulse to a single cycle even
            // if two causes land back to back.
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    inc_pulse <= user_inc && !inc_pulse;
                    dec_pulse <= user_dec && !dec_pulse;
                    if (gear_sw != gear_active) begin
                        target     <= gear_sw;
                        stable_cnt <= 16'd0;
                        state      <= DEBOUNCE;
                        busy       <= 1'b1;
                    end
                end

                DEBOUNCE: begin
                    inc_pulse <= user_inc && !inc_pulse;
                    dec_pulse <= user_dec && !dec_pulse;
                    if (gear_sw != target) begin
                        target     <= gear_sw;
                        stable_cnt <= 16'd0;
                    end else if (stable_cnt >= STABLE_LIM) begin
                        if (target == GEAR_INVALID) begin
                            fault <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (speed_level > target_ceil) begin
                            // Entry step; any user inc this cycle is dropped
                            // so the two commands never coincide.
                            inc_pulse <= 1'b0;
                            dec_pulse <= !dec_pulse;
                            step_cnt  <= 16'd0;
                            state     <= SHIFT_DOWN;
                        end else begin
                            state <= COMMIT;
                        end
                    end else if (tick_1khz) begin
                        stable_cnt <= stable_cnt + 16'd1;
                    end
                end

                SHIFT_DOWN: begin
                    dec_pulse <= sd_dec && !dec_pulse;
                    if (gear_sw != target) begin
                        target     <= gear_sw;
                        stable_cnt <= 16'd0;
                        step_cnt   <= 16'd0;
                        state      <= DEBOUNCE;
                    end else if (speed_level <= target_ceil) begin
                        state <= COMMIT;
                    end else if (decel_pulse) begin
                        // A user step restarts the interval so the automatic
                        // step cannot follow it immediately.
                        step_cnt <= 16'd0;
                    end else if (tick_1khz) begin
                        if (step_cnt + 16'd1 >= STEP_LIM) begin
                            step_cnt  <= 16'd0;
                            dec_pulse <= !dec_pulse;
                        end else begin
                            step_cnt <= step_cnt + 16'd1;
                        end
                    end
                end

                COMMIT: begin
                    inc_pulse   <= user_inc && !inc_pulse;
                    dec_pulse   <= user_dec && !dec_pulse;
                    gear_active <= target;
                    max_level   <= gear_ceiling(target);
                    fault       <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
